// File: rtl/backward_maccum_pkg.sv
// Shared helpers for the backward multiply-accumulate datapath: pipeline mode
// names, accumulator width and the saturating fixed-point product.
package nn_pkg;

  localparam string BURST_YES = "yes";
  localparam string BURST_NO  = "no";

  // Accumulator width for a sum of n terms of width wf; wide enough that it cannot overflow.
  function automatic int accw(input int n, input int wf);
    return $clog2(n) + wf;
  endfunction

  // Q1.(wf-1) product: full-precision multiply, floor shift, then clamp to wf bits.
  function automatic logic signed [31:0] sat_mul_q(input logic signed [31:0] a,
                                                  input logic signed [31:0] b,
                                                  input int wf);
    logic signed [63:0] prod;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    prod = 64'(a) * 64'(b);
    prod = prod >>> (wf - 1);
    hi   = (64'sd1 <<< (wf - 1)) - 64'sd1;
    lo   = -hi - 64'sd1;
    if (prod > hi) begin
      prod = hi;
    end else if (prod < lo) begin
      prod = lo;
    end
    return 32'(prod);
  endfunction

endpackage

// File: rtl/backward_maccum_pipe_stage.sv
// One valid/ready register slice. In pipelined mode it accepts while the
// downstream pops (full throughput); otherwise it only accepts when empty.
module pipe_stage
  import nn_pkg::*;
#(
  parameter int    W     = 8,
  parameter string BURST = BURST_YES
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  localparam bit PIPELINED = (BURST != BURST_NO);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  if (PIPELINED) begin : g_burst
    assign ready_o = !valid_q | ready_i;
  end else begin : g_single
    assign ready_o = !valid_q;
  end

  assign load = valid_i & ready_o;

  // Next state: load new word, otherwise drop valid once the consumer takes it; data held while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slice registers, cleared immediately by reset so no partial word escapes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/backward_maccum.sv
// Backward-pass MAC: joins the weight and child-delta streams, registers the
// saturated products (S1), then registers per-parent sums (S2) to the output.
module backward_maccum
  import nn_pkg::*;
#(
  parameter int    NP    = 3,
  parameter int    NC    = 2,
  parameter int    WF    = 8,
  parameter string BURST = BURST_YES
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iValid_AM_Weight,
  output logic                          oReady_AM_Weight,
  input  logic [NP*NC*WF-1:0]           iData_AM_Weight,
  input  logic                          iValid_AM_Delta1,
  output logic                          oReady_AM_Delta1,
  input  logic [NC*WF-1:0]              iData_AM_Delta1,
  output logic                          oValid_BM_Accum,
  input  logic                          iReady_BM_Accum,
  output logic [NP*accw(NC, WF)-1:0]    oData_BM_Accum
);

  localparam int AW        = accw(NC, WF);
  localparam int PW        = NP * NC * WF;
  localparam int SW        = NP * AW;
  localparam bit PIPELINED = (BURST != BURST_NO);

  logic          ready_en_q;
  logic          accept;
  logic          fire;
  logic          s1_ready, s1_valid, s2_ready;
  logic [PW-1:0] prod_d;
  logic [PW-1:0] s1_data;
  logic [SW-1:0] sum_d;

  // Inputs stay blocked during reset and open on the first edge after release.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // Single-in-flight mode also waits for S2 to empty, i.e. for the output handshake.
  assign accept           = ready_en_q & s1_ready & (PIPELINED | !oValid_BM_Accum);
  assign oReady_AM_Weight = accept;
  assign oReady_AM_Delta1 = accept;
  // Both streams are consumed together or not at all.
  assign fire             = accept & iValid_AM_Weight & iValid_AM_Delta1;

  // Products: index gi = p*NC + c pairs W[p][c] with delta[c].
  for (genvar gi = 0; gi < NP * NC; gi++) begin : g_prod
    assign prod_d[gi*WF +: WF] = WF'(sat_mul_q(
        32'($signed(iData_AM_Weight[gi*WF +: WF])),
        32'($signed(iData_AM_Delta1[(gi % NC)*WF +: WF])),
        WF));
  end

  // Per-parent adder over the registered products, sign-extended to AW bits.
  for (genvar gi = 0; gi < NP; gi++) begin : g_sum
    logic signed [AW-1:0] acc;
    // Sum the NC products belonging to parent gi.
    always_comb begin
      acc = '0;
      for (int c = 0; c < NC; c++) begin
        acc = acc + AW'($signed(s1_data[(gi*NC + c)*WF +: WF]));
      end
    end
    assign sum_d[gi*AW +: AW] = acc;
  end

  pipe_stage #(.W(PW), .BURST(BURST)) u_s1 (
    .clk_i   (iCLK),
    .rst_ni  (iRST),
    .valid_i (fire),
    .ready_o (s1_ready),
    .data_i  (prod_d),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_data)
  );

  pipe_stage #(.W(SW), .BURST(BURST)) u_s2 (
    .clk_i   (iCLK),
    .rst_ni  (iRST),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (sum_d),
    .valid_o (oValid_BM_Accum),
    .ready_i (iReady_BM_Accum),
    .data_o  (oData_BM_Accum)
  );

endmodule
